// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiator.
//   mem_state_t  : FSM state encoding (IDLE, WRITE, READ, RESP)
//   MEM_ADDR_W   : default address width
//   MEM_DATA_W   : default data width
//   MAX_READ_LAT : largest supported read latency (fits the 3-bit counter)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  localparam int unsigned MEM_ADDR_W   = 16;
  localparam int unsigned MEM_DATA_W   = 16;
  localparam int unsigned MAX_READ_LAT = 7;
  localparam int unsigned LAT_CNT_W    = 3;

endpackage

// File: rtl/mem_master.sv
// mem_master: initiator side of the 16-bit data-memory port.
// Accepts one load/store at a time over a valid/ready request channel,
// drives memwrite/memread/address/writedata into Memory, samples readdata
// after READ_LAT cycles of memread and returns it on a buffered response.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake
//   req_write/addr/wdata       request fields (sampled only at accept)
//   rsp_valid/rsp_ready        load-response handshake
//   rsp_rdata                  load data, stable while rsp_valid
//   busy                       high whenever the FSM is not IDLE
//   memwrite/memread           memory strobes (mutually exclusive)
//   address/writedata          memory address / store data
//   readdata                   memory read data
module mem_master
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned DATA_W   = MEM_DATA_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              memwrite,
  output logic              memread,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_read_lat
    $error("mem_master: READ_LAT=%0d outside 1..%0d", READ_LAT, MAX_READ_LAT);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT - 1);

  mem_state_t           state_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]    address_q;
  logic [DATA_W-1:0]    writedata_q;
  logic [DATA_W-1:0]    rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      address_q   <= '0;
      writedata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            address_q <= req_addr;
            if (req_write) begin
              writedata_q <= req_wdata;
              state_q     <= WRITE;
            end else begin
              cnt_q   <= LAT_LOAD;
              state_q <= READ;
            end
          end
        end
        WRITE: begin
          // writedata is only meaningful alongside memwrite
          writedata_q <= '0;
          state_q     <= IDLE;
        end
        READ: begin
          if (cnt_q == '0) begin
            rsp_rdata_q <= readdata;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes and handshake outputs decode the state register only, so reset
  // drops them immediately and no input reaches an output combinationally.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign memwrite  = (state_q == WRITE);
  assign memread   = (state_q == READ);
  assign rsp_valid = (state_q == RESP);
  assign address   = address_q;
  assign writedata = writedata_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
module tb_mem_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance, READ_LAT = 1, with a behavioural memory behind it
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic        busy, memwrite, memread;
  logic [15:0] address, writedata, readdata;

  mem_master #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .memwrite(memwrite), .memread(memread),
    .address(address), .writedata(writedata), .readdata(readdata)
  );

  // second instance, READ_LAT = 3, readdata driven directly by the bench
  logic        req_valid_3, req_ready_3, req_write_3;
  logic [15:0] req_addr_3, req_wdata_3;
  logic        rsp_valid_3, rsp_ready_3;
  logic [15:0] rsp_rdata_3;
  logic        busy_3, memwrite_3, memread_3;
  logic [15:0] address_3, writedata_3, readdata_3;

  mem_master #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write_3),
    .req_addr(req_addr_3), .req_wdata(req_wdata_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_rdata(rsp_rdata_3),
    .busy(busy_3), .memwrite(memwrite_3), .memread(memread_3),
    .address(address_3), .writedata(writedata_3), .readdata(readdata_3)
  );

  logic [15:0] mem [0:65535];
  always @(posedge clk) if (memwrite) mem[address] <= writedata;
  assign readdata = mem[address];

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard: expected load data pushed on accept, popped on handshake
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [int];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (req_valid && req_ready) begin
          if (req_write) ref_mem[int'(req_addr)] = req_wdata;
          else exp_q.push_back(ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : 16'h0);
        end
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) chk("sb_rdata", {16'd0, rsp_rdata}, {16'd0, exp_q.pop_front()});
          n_rsp++;
        end
        chk("strobe_overlap", {31'd0, memwrite & memread}, 32'd0);
        if (!memwrite) chk("wdata_idle_zero", {16'd0, writedata}, 32'd0);
        chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned hold;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [9];

  // Caller is at posedge+1. Returns at posedge+1 with the block back in IDLE.
  task automatic do_req(input vec_t v);
    int n;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready || n >= 20) break;
      n++;
      @(posedge clk); #1;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~v.wr; req_addr = 16'(~v.addr); req_wdata = 16'($urandom);
    if (v.wr) begin
      chk("wr_memwrite", {31'd0, memwrite}, 32'd1);
      chk("wr_address", {16'd0, address}, {16'd0, v.addr});
      chk("wr_writedata", {16'd0, writedata}, {16'd0, v.wdata});
      chk("wr_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("wr_done_memwrite", {31'd0, memwrite}, 32'd0);
      chk("wr_done_ready", {31'd0, req_ready}, 32'd1);
      chk("wr_addr_hold", {16'd0, address}, {16'd0, v.addr});
    end else begin
      chk("rd_address", {16'd0, address}, {16'd0, v.addr});
      n = 0;
      while (memread && n < 10) begin
        n++;
        @(posedge clk); #1;
      end
      chk("rd_memread_cycles", n, 32'd1);
      chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_rdata", {16'd0, rsp_rdata}, {16'd0, v.exp});
      for (int unsigned i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rdata", {16'd0, rsp_rdata}, {16'd0, v.exp});
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, rsp0;
    vecs[0] = '{1'b1, 16'h0000, 16'h1111, 0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 0, 16'h1111};
    vecs[2] = '{1'b1, 16'h1234, 16'h9999, 0, 16'h0000};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 3, 16'h9999};
    vecs[4] = '{1'b1, 16'h00FF, 16'hABCD, 0, 16'h0000};
    vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 1, 16'hABCD};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 0, 16'h1111};
    vecs[7] = '{1'b1, 16'hFFFF, 16'h5A5A, 0, 16'h0000};
    vecs[8] = '{1'b0, 16'hFFFF, 16'h0000, 2, 16'h5A5A};

    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    req_valid_3 = 0; req_write_3 = 0; req_addr_3 = '0; req_wdata_3 = '0; rsp_ready_3 = 0;
    readdata_3 = '0;

    // idle reset values
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_memread", {31'd0, memread}, 32'd0);
    chk("rst_address", {16'd0, address}, 32'd0);
    chk("rst_writedata", {16'd0, writedata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_req(vecs[i]);

    // back-to-back alternating store/load with req_valid and rsp_ready held high
    rsp_ready = 1'b1;
    rsp0 = n_rsp;
    k = 0; n = 0;
    req_valid = 1'b1;
    while (k < 8 && n < 100) begin
      req_write = (k % 2 == 0);
      req_addr  = 16'h0010;
      req_wdata = 16'h1000 + 16'(k);
      @(negedge clk);
      if (req_ready) k++;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("alt_accept_edges", n, 32'd18);
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("alt_queue_empty", exp_q.size(), 32'd0);
    chk("alt_rsp_count", n_rsp - rsp0, 32'd4);
    rsp_ready = 1'b0;
    @(posedge clk); #1;

    // reset during a load: no response afterwards
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
    @(negedge clk);
    chk("rstld_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstld_memread", {31'd0, memread}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstld_memread_drop", {31'd0, memread}, 32'd0);
    chk("rstld_busy_drop", {31'd0, busy}, 32'd0);
    chk("rstld_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstld_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    do_req('{1'b0, 16'h1234, 16'h0000, 0, 16'h9999});

    // READ_LAT = 3 instance: memread for 3 cycles, glitch on readdata ignored
    req_valid_3 = 1'b1; req_write_3 = 1'b0; req_addr_3 = 16'h0042;
    readdata_3 = 16'hBEEF;
    @(negedge clk);
    chk("l3_ready", {31'd0, req_ready_3}, 32'd1);
    @(posedge clk); #1;
    req_valid_3 = 1'b0; req_addr_3 = 16'h7777;
    readdata_3 = 16'h0BAD;
    chk("l3_memread_c0", {31'd0, memread_3}, 32'd1);
    chk("l3_address", {16'd0, address_3}, 32'h0042);
    @(posedge clk); #1;
    chk("l3_memread_c1", {31'd0, memread_3}, 32'd1);
    chk("l3_no_early_valid", {31'd0, rsp_valid_3}, 32'd0);
    @(posedge clk); #1;
    readdata_3 = 16'hBEEF;
    chk("l3_memread_c2", {31'd0, memread_3}, 32'd1);
    chk("l3_no_early_valid2", {31'd0, rsp_valid_3}, 32'd0);
    @(posedge clk); #1;
    readdata_3 = 16'h0000;
    chk("l3_memread_off", {31'd0, memread_3}, 32'd0);
    chk("l3_rsp_valid", {31'd0, rsp_valid_3}, 32'd1);
    chk("l3_rdata", {16'd0, rsp_rdata_3}, 32'hBEEF);
    @(posedge clk); #1;
    chk("l3_rdata_stable", {16'd0, rsp_rdata_3}, 32'hBEEF);
    chk("l3_ready_low", {31'd0, req_ready_3}, 32'd0);
    rsp_ready_3 = 1'b1;
    @(posedge clk); #1;
    rsp_ready_3 = 1'b0;
    chk("l3_done_valid", {31'd0, rsp_valid_3}, 32'd0);
    chk("l3_done_ready", {31'd0, req_ready_3}, 32'd1);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
